key_scan_4x4: RTL and testbench
===============================

Name: key_scan_4x4

Overview:
- Scanner for the trainer's 4x4 hex keypad matrix.
- This block is the input side of the front panel; the 7-segment display multiplexer is the output side.
- Rotates an active-low drive across the four rows and samples the four column inputs. It debounces over whole scans and presents one 4-bit key code to the CPU-side glue with a valid/ack handshake.
- Sits beside the display driver on the panel bus. Row pins and column pins are shared with the board keypad connector.

Parameters:
- SCAN_DIV, 1000: clk cycles each row is driven before its columns are sampled. Minimum 4.
- DEBOUNCE_SCANS, 8: consecutive identical full-scan results needed to accept a press or a release. Range 1..255.

Ports:
- clk  in  1  system clock
- nrst  in  1  reset, asynchronous, active-low
- row_n  out  4  row drive, active-low one-hot; exactly one bit low at all times
- col_n  in  4  column sense, active-low, externally pulled up, asynchronous to clk
- key_code  out  4  code of accepted key, {row_idx[1:0], col_idx[1:0]}
- key_valid  out  1  high while key_code holds an unacknowledged key
- key_ack  in  1  consumer acknowledge, single-cycle pulse or level
- key_down  out  1  high from press acceptance until release acceptance
- overrun  out  1  one-cycle pulse when a press is accepted while key_valid is still high

Behaviour:
- Reset values:
  - row_n = 4'b1110 (row 0)
  - key_code = 0, key_valid = 0, key_down = 0, overrun = 0
  - divider = 0, debounce count = 0
  - state = IDLE
  - synchroniser flops = 4'b1111
- Column synchroniser: col_n passes through 2 flops before any use.
- Divider: counts 0..SCAN_DIV-1. At terminal count (tc):
  - sample the synchronised columns into the snapshot slice for the current row;
  - rotate row_n left: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Scan end: tc while row 3 is driven. The 16-bit snapshot is classified using the current row-3 sample:
  - NONE: no bit low
  - SINGLE(code): exactly one bit low, code = row*4+col
  - MULTI: two or more bits low
- All state-machine decisions happen only on the scan-end cycle. Outside scan end the FSM holds.
- FSM states: IDLE, PRESS_DB, DOWN, RELEASE_DB.
  - IDLE:
    - SINGLE(c): cand <= c, cnt <= 1. Go to PRESS_DB; if DEBOUNCE_SCANS==1, accept immediately instead.
    - Otherwise stay.
  - PRESS_DB:
    - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, accept.
    - SINGLE(other): cand <= other, cnt <= 1.
    - NONE or MULTI: go to IDLE, cnt <= 0.
  - Accept:
    - If key_valid==0: key_code <= cand, key_valid <= 1.
    - Else: key_code unchanged, overrun pulses for 1 cycle (the new key is dropped).
    - In both cases: key_down <= 1, state <= DOWN.
  - DOWN:
    - NONE: cnt <= 1, go to RELEASE_DB; if DEBOUNCE_SCANS==1, go straight to IDLE with key_down <= 0.
    - SINGLE or MULTI: stay. Rollover to a second key is ignored until full release.
  - RELEASE_DB:
    - NONE: cnt++. At DEBOUNCE_SCANS, key_down <= 0 and go to IDLE.
    - Any key: go to DOWN.
- Handshake:
  - key_valid clears on the cycle after key_ack is sampled high.
  - If ack and accept coincide in one cycle, ack wins first: key_valid stays 1, key_code <= cand, no overrun.
  - key_ack while key_valid==0 is ignored.
- Output timing: key_valid/key_code update 1 cycle after the scan-end clock edge; all outputs are registered.
- Scan period = 4*SCAN_DIV cycles. Press latency after contacts settle is at most (DEBOUNCE_SCANS+1) scan periods + 3 cycles.
- The debounce counter is 8 bits and saturates; it never wraps.
- Asynchronous reset mid-scan or mid-debounce returns everything to reset values immediately. Any pending key is lost.

Decomposition:
- Package kbd_pkg:
  - typedef enum logic [1:0] kbd_state_t {IDLE, PRESS_DB, DOWN, RELEASE_DB}
  - typedef logic [3:0] key_code_t
  - typedef enum scan class {NONE, SINGLE, MULTI}
  - localparam ROW_RESET = 4'b1110
- One sub-module, kbd_scan_classify: purely combinational. Takes the 16-bit snapshot and returns class plus code.
- Synchroniser, divider, row rotation and FSM stay in key_scan_4x4.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, so the scan period is 16 clocks.
- Reset/rotation: release nrst, observe row_n -> 1110 for 4 clk, then 1101, 1011, 0111, 1110. All outputs 0 throughout.
- Clean press: hold the row2/col1 contact -> key_valid=1 with key_code=4'h9 at the end of the 3rd full qualifying scan. key_down=1. Pulse key_ack -> key_valid=0 next cycle, key_down stays 1.
- Bounce: toggle key 5 present/absent on alternate scans for 6 scans -> key_valid stays 0. Then hold 3 scans -> key_code=4'h5.
- Release and second key: release key 9 -> key_down=0 after 3 NONE scans. Press key 4'hF without acking key 9 -> overrun pulses once, key_code stays 4'h9.
- Multi-key: press keys 0 and 3 together from IDLE for 5 scans -> no acceptance, state stays IDLE.
- Reset mid-DOWN: assert nrst while key_down=1 -> all outputs 0 and row_n=1110 in the same cycle, asynchronously.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types for the front-panel keypad scanner: FSM states, key codes,
// snapshot classes and the row-drive reset pattern.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        DOWN       = 2'd2,
        RELEASE_DB = 2'd3
    } kbd_state_t;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_class_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;

    // Number of closed contacts in an active-low snapshot
    function automatic logic [4:0] count_low(input logic [15:0] snap);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, ~snap[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/kbd_scan_classify.sv
// Combinational classification of one full 16-contact snapshot into
// no key / exactly one key (with its code) / several keys.
module kbd_scan_classify
    import kbd_pkg::*;
(
    input  logic [15:0] i_snap,
    output scan_class_t o_class,
    output key_code_t   o_code
);

    logic [4:0] w_nlow;

    // Code is only meaningful for SINGLE, so any low bit may set it
    always_comb begin
        w_nlow = count_low(i_snap);
        o_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!i_snap[i]) begin
                o_code = key_code_t'(i);
            end else begin
                o_code = o_code;
            end
        end
        case (w_nlow)
            5'd0:    o_class = NONE;
            5'd1:    o_class = SINGLE;
            default: o_class = MULTI;
        endcase
    end

endmodule

// File: rtl/key_scan_4x4.sv
// 4x4 hex keypad scanner: rotating active-low row drive, per-scan debounce
// of press and release, and a valid/ack key-code handshake with overrun flag.
module key_scan_4x4
    import kbd_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       nrst,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int              DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]      DB_TARGET = 8'(DEBOUNCE_SCANS);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row_idx;
    logic [3:0]       r_row_n;
    logic [11:0]      r_snap;
    kbd_state_t       r_state;
    logic [7:0]       r_cnt;
    key_code_t        r_cand;
    key_code_t        r_key_code;
    logic             r_key_valid;
    logic             r_key_down;
    logic             r_overrun;

    logic             w_tc;
    logic             w_scan_end;
    logic [15:0]      w_snap_full;
    scan_class_t      w_class;
    key_code_t        w_code;
    logic [7:0]       w_cnt_inc;
    logic             w_ack;
    logic             w_accept;

    assign w_tc        = (r_div == DIV_LAST);
    assign w_scan_end  = w_tc && (r_row_idx == 2'd3);
    assign w_snap_full = {r_sync2, r_snap};
    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : (r_cnt + 8'd1);
    assign w_ack       = key_ack && r_key_valid;

    kbd_scan_classify u_classify (
        .i_snap  (w_snap_full),
        .o_class (w_class),
        .o_code  (w_code)
    );

    // Press acceptance: immediate from IDLE when one scan suffices,
    // otherwise when the candidate has been seen DEBOUNCE_SCANS times
    always_comb begin
        w_accept = 1'b0;
        if (w_scan_end && (w_class == SINGLE)) begin
            if (r_state == IDLE) begin
                w_accept = (DB_TARGET == 8'd1);
            end else if (r_state == PRESS_DB) begin
                w_accept = (w_code == r_cand) && (w_cnt_inc >= DB_TARGET);
            end else begin
                w_accept = 1'b0;
            end
        end else begin
            w_accept = 1'b0;
        end
    end

    // Two-flop synchroniser for the asynchronous column inputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= 4'b1111;
            r_sync2 <= 4'b1111;
        end else begin
            r_sync1 <= col_n;
            r_sync2 <= r_sync1;
        end
    end

    // Row divider, row rotation and per-row column snapshot
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div     <= '0;
            r_row_idx <= 2'd0;
            r_row_n   <= ROW_RESET;
            r_snap    <= 12'hFFF;
        end else if (w_tc) begin
            r_div     <= '0;
            r_row_idx <= r_row_idx + 2'd1;
            r_row_n   <= {r_row_n[2:0], r_row_n[3]};
            if (r_row_idx != 2'd3) begin
                r_snap[{r_row_idx, 2'b00} +: 4] <= r_sync2;
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Debounce FSM and handshake; ack is honoured before a coinciding accept
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_cand      <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_accept) begin
                r_state    <= DOWN;
                r_cnt      <= 8'd0;
                r_cand     <= w_code;
                r_key_down <= 1'b1;
                if (!r_key_valid || w_ack) begin
                    r_key_code  <= w_code;
                    r_key_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else begin
                if (w_ack) begin
                    r_key_valid <= 1'b0;
                end
                if (w_scan_end) begin
                    case (r_state)
                        IDLE: begin
                            if (w_class == SINGLE) begin
                                r_cand  <= w_code;
                                r_cnt   <= 8'd1;
                                r_state <= PRESS_DB;
                            end
                        end
                        PRESS_DB: begin
                            if (w_class == SINGLE) begin
                                if (w_code == r_cand) begin
                                    r_cnt <= w_cnt_inc;
                                end else begin
                                    r_cand <= w_code;
                                    r_cnt  <= 8'd1;
                                end
                            end else begin
                                r_state <= IDLE;
                                r_cnt   <= 8'd0;
                            end
                        end
                        DOWN: begin
                            if (w_class == NONE) begin
                                if (DB_TARGET == 8'd1) begin
                                    r_key_down <= 1'b0;
                                    r_state    <= IDLE;
                                    r_cnt      <= 8'd0;
                                end else begin
                                    r_cnt   <= 8'd1;
                                    r_state <= RELEASE_DB;
                                end
                            end
                        end
                        RELEASE_DB: begin
                            if (w_class == NONE) begin
                                if (w_cnt_inc >= DB_TARGET) begin
                                    r_key_down <= 1'b0;
                                    r_state    <= IDLE;
                                    r_cnt      <= 8'd0;
                                end else begin
                                    r_cnt <= w_cnt_inc;
                                end
                            end else begin
                                r_state <= DOWN;
                            end
                        end
                        default: begin
                            r_state <= IDLE;
                            r_cnt   <= 8'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign row_n     = r_row_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_down  = r_key_down;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_key_scan_4x4.sv
// Bench for key_scan_4x4: a keypad matrix model drives col_n from row_n, and a
// scan-level run-length reference model predicts the handshake outputs.
module tb_key_scan_4x4;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk;
    logic       nrst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_down;
    logic       overrun;

    logic [15:0] keys;

    int n_cmp;
    int n_bad;

    // reference model state
    int         last_tag;
    int         run_len;
    bit         m_valid;
    bit         m_down;
    logic [3:0] m_code;
    bit         exp_ovr;

    key_scan_4x4 #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a closed contact pulls its column low while its row is driven
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

    task automatic model_reset();
        last_tag = -1;
        run_len  = 0;
        m_valid  = 1'b0;
        m_down   = 1'b0;
        m_code   = 4'h0;
        exp_ovr  = 1'b0;
    endtask

    // A press is accepted when DEB identical single-key scans in a row are seen
    // while no key is held; a release when DEB empty scans in a row are seen.
    task automatic model_scan(input logic [15:0] k, input bit ack_end);
        int n;
        int code;
        int cls;
        int tag;
        bit hit;
        n    = $countones(k);
        code = 0;
        for (int b = 0; b < 16; b++) if (k[b]) code = b;
        cls = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
        tag = cls * 16 + ((cls == 1) ? code : 0);
        if (tag == last_tag) run_len++;
        else begin
            run_len  = 1;
            last_tag = tag;
        end
        exp_ovr = 1'b0;
        hit     = ack_end && m_valid;
        if (!m_down && cls == 1 && run_len == DEB) begin
            m_down = 1'b1;
            if (!m_valid || hit) begin
                m_valid = 1'b1;
                m_code  = code[3:0];
            end else begin
                exp_ovr = 1'b1;
            end
        end else begin
            if (m_down && cls == 0 && run_len == DEB) m_down = 1'b0;
            if (hit) m_valid = 1'b0;
        end
    endtask

    // One full scan with keys held; optional ack mid-scan or on the scan-end edge
    task automatic run_scan(input logic [15:0] k, input bit ack_mid, input bit ack_end);
        keys = k;
        for (int i = 1; i <= 16; i++) begin
            key_ack = (ack_mid && i == 6) || (ack_end && i == 16);
            @(posedge clk);
            #1;
            key_ack = 1'b0;
            if (i == 1) begin
                n_cmp++;
                if (overrun !== 1'b0) begin
                    n_bad++;
                    $display("FAIL overrun_width: actual=%0b required=0", overrun);
                end
            end
            if (ack_mid && i == 6) begin
                m_valid = 1'b0;
                n_cmp++;
                if (key_valid !== m_valid || key_down !== m_down) begin
                    n_bad++;
                    $display("FAIL ack_clear: actual valid=%0b down=%0b required valid=%0b down=%0b",
                             key_valid, key_down, m_valid, m_down);
                end
            end
        end
        model_scan(k, ack_end);
        n_cmp++;
        if (key_valid !== m_valid) begin
            n_bad++;
            $display("FAIL key_valid keys=%h: actual=%0b required=%0b", k, key_valid, m_valid);
        end
        n_cmp++;
        if (m_valid && key_code !== m_code) begin
            n_bad++;
            $display("FAIL key_code keys=%h: actual=%h required=%h", k, key_code, m_code);
        end
        n_cmp++;
        if (key_down !== m_down) begin
            n_bad++;
            $display("FAIL key_down keys=%h: actual=%0b required=%0b", k, key_down, m_down);
        end
        n_cmp++;
        if (overrun !== exp_ovr) begin
            n_bad++;
            $display("FAIL overrun keys=%h: actual=%0b required=%0b", k, overrun, exp_ovr);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_row;
        nrst    = 1'b0;
        key_ack = 1'b0;
        keys    = 16'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({row_n, key_code, key_valid, key_down, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_values: actual row=%b code=%h v=%0b d=%0b o=%0b required row=1110 rest 0",
                     row_n, key_code, key_valid, key_down, overrun);
        end
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            n_cmp++;
            if (row_n !== exp_row || {key_code, key_valid, key_down, overrun} !== 7'd0) begin
                n_bad++;
                $display("FAIL rotation cycle %0d: actual row=%b outs=%h required row=%b outs=0",
                         i, row_n, {key_code, key_valid, key_down, overrun}, exp_row);
            end
        end
        model_scan(16'h0, 1'b0);
    endtask

    task automatic test_clean_press();
        for (int s = 0; s < 3; s++) run_scan(16'h0200, 1'b0, 1'b0);
        run_scan(16'h0200, 1'b1, 1'b0);
    endtask

    task automatic test_bounce();
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, 1'b0);
        for (int s = 0; s < 6; s++) run_scan((s % 2 == 0) ? 16'h0020 : 16'h0000, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) run_scan(16'h0020, 1'b0, 1'b0);
        run_scan(16'h0020, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_release_second();
        for (int s = 0; s < 3; s++) run_scan(16'h0200, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) run_scan(16'h8000, 1'b0, 1'b0);
    endtask

    task automatic test_ack_collision();
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, 1'b0);
        run_scan(16'h0040, 1'b0, 1'b0);
        run_scan(16'h0040, 1'b0, 1'b0);
        run_scan(16'h0040, 1'b0, 1'b1);
        run_scan(16'h0040, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_multi();
        for (int s = 0; s < 5; s++) run_scan(16'h0009, 1'b0, 1'b0);
        run_scan(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] k;
        int sel;
        int a;
        int b;
        k = 16'h0;
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                k = k;
            end else if (sel <= 5) begin
                k = 16'h0;
            end else if (sel <= 8) begin
                k = 16'h0001 << $urandom_range(0, 15);
            end else begin
                a = $urandom_range(0, 15);
                b = (a + $urandom_range(1, 15)) % 16;
                k = (16'h0001 << a) | (16'h0001 << b);
            end
            run_scan(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic test_reset_mid_down();
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) run_scan(16'h0400, 1'b0, 1'b0);
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({row_n, key_code, key_valid, key_down, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
            n_bad++;
            $display("FAIL async_reset: actual row=%b code=%h v=%0b d=%0b o=%0b required row=1110 rest 0",
                     row_n, key_code, key_valid, key_down, overrun);
        end
        @(negedge clk);
        nrst = 1'b1;
        model_reset();
        for (int s = 0; s < 2; s++) run_scan(16'h0400, 1'b0, 1'b0);
        run_scan(16'h0400, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_second();
        test_ack_collision();
        test_multi();
        test_random();
        test_reset_mid_down();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
